shifter_seq_rev: RTL and testbench
==================================

# shifter_seq_rev

Multi-cycle, handshaked shifter that performs the opposite-direction shift operations to the processor's combinational shifter: shift right logical, shift left arithmetic and rotate left. It moves one bit position per clock and holds its result until the consumer takes it. It sits beside the ALU as the unit for the reverse-direction shift and rotate opcodes.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits.
- CNT_W, 4: shift-amount width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- In_Valid  in  1  the operation on Shift_In, Shift_Val and Mode is offered.
- In_Ready  out  1  the block can accept an operation; high only in IDLE.
- Shift_In  in  WIDTH  operand.
- Shift_Val  in  CNT_W  shift amount, 0..WIDTH-1.
- Mode  in  2  operation select: 00 SRL, 01 SLA, 10 ROL, 11 PASS.
- Out_Valid  out  1  Shift_Out and Ovf are valid; high only in DONE.
- Out_Ready  in  1  the consumer accepts the result.
- Shift_Out  out  WIDTH  result.
- Ovf  out  1  sticky SLA overflow flag (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: In_Ready=1. When In_Valid is high at an edge, the block loads the data register with Shift_In, loads cnt with Shift_Val, latches Mode, clears Ovf and moves to SHIFT. In PASS mode cnt is loaded with 0 regardless of Shift_Val.
- SHIFT, with cnt != 0: one single-position step, then cnt decrements.
  - SRL: {0, d[W-1:1]}.
  - SLA: {d[W-2:0], 0}; Ovf is set if d[W-1] != d[W-2] before the step.
  - ROL: {d[W-2:0], d[W-1]}.
- SHIFT, with cnt == 0: move to DONE with no data change.
- DONE: Out_Valid=1, and Shift_Out and Ovf are held stable. When Out_Ready is high at an edge, the block moves to IDLE. Shift_Out keeps its last value in IDLE.
- Shift_Out always reflects the data register. Its value outside DONE carries no meaning.
- Out_Ready is ignored outside DONE. In_Valid is ignored outside IDLE, so a held In_Valid is not re-accepted until the block returns to IDLE.
- The block does not overlap operations: the next accept can occur no earlier than the edge after the DONE-exit edge.

## Timing
- Reset values: state IDLE, In_Ready=1, Out_Valid=0, Shift_Out=0, Ovf=0, cnt=0.
- rst is synchronous and wins over all other inputs. Asserting rst in SHIFT or DONE discards the operation, and the reset values hold from the next edge.
- Latency: if the accept happens at edge E0, Out_Valid rises after edge E0+N+1, where N is the effective count (0 for PASS).
- Minimum occupancy is N+2 cycles per operation when Out_Ready is held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SHIFT_OVF_EN defined: Ovf is computed as described for SLA, and it is 0 for all other modes.
- SHIFT_OVF_EN undefined: no overflow logic is built. The Ovf port remains and is constant 0.

## Structure
- Shared package shifter_pkg holds:
  - the mode encodings (SRL/SLA/ROL/PASS) as an enum;
  - the FSM state enum;
  - the WIDTH default.
- Sub-module shift_step: combinational single-position step. It takes d and mode and returns next_d and step_ovf. It is instantiated once inside shifter_seq_rev.

## Test plan
- SRL, Shift_In=0x8001, Shift_Val=4, Out_Ready=1 -> Shift_Out=0x0800 with Out_Valid after 5 edges, then In_Ready=1 on the next edge.
- ROL, 0x8001 by 4 -> 0x0018. ROL, 0xF00F by 15 -> 0xF807.
- SLA, 0x4000 by 1 -> 0x8000 with Ovf=1 (when SHIFT_OVF_EN is defined). SLA, 0xFFFF by 3 -> 0xFFF8 with Ovf=0. Without SHIFT_OVF_EN, Ovf=0 in both cases.
- PASS, 0x1234 with Shift_Val=9 -> 0x1234 with Out_Valid after 1 edge. SRL, 0xABCD by 0 -> 0xABCD with Out_Valid after 1 edge.
- Backpressure: hold Out_Ready=0 for 3 cycles in DONE -> Out_Valid and Shift_Out remain stable, In_Valid pulses during this time are ignored, and the result is released when Out_Ready=1.
- Assert rst during SHIFT (SRL 0xFFFF by 12, 5 cycles in) -> the next edge gives Out_Valid=0, Shift_Out=0, In_Ready=1, and no result is ever produced.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the reverse-direction sequential shifter:
// operation encodings, FSM states and the default datapath width.
package shifter_pkg;

    localparam int WIDTH_DEF = 16;

    // Operation select as carried on the Mode port
    typedef enum logic [1:0] {
        MODE_SRL  = 2'b00,
        MODE_SLA  = 2'b01,
        MODE_ROL  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shifter_seq_rev_if.sv
// Request/response bundle between a producer/consumer (master) and the
// sequential shifter (slave).
interface shifter_seq_rev_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] Shift_In;
    logic [CNT_W-1:0] Shift_Val;
    logic [1:0]       Mode;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Shift_Out;
    logic             Ovf;

    modport master (
        output In_Valid, Shift_In, Shift_Val, Mode, Out_Ready,
        input  In_Ready, Out_Valid, Shift_Out, Ovf
    );

    modport slave (
        input  In_Valid, Shift_In, Shift_Val, Mode, Out_Ready,
        output In_Ready, Out_Valid, Shift_Out, Ovf
    );
endinterface

// File: rtl/shifter_seq_rev_step.sv
// shift_step: combinational single-bit-position step of the shifter.
// Overflow detection is only built when SHIFT_OVF_EN is defined;
// otherwise step_ovf is tied to 0.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] d,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_d,
    output logic             step_ovf
);

    logic [WIDTH-1:0] srl_d;
    logic [WIDTH-1:0] sla_d;
    logic [WIDTH-1:0] rol_d;

    // Per-bit wiring of the three one-position moves
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == WIDTH - 1) begin : g_top
            assign srl_d[gi] = 1'b0;
        end else begin : g_not_top
            assign srl_d[gi] = d[gi+1];
        end
        if (gi == 0) begin : g_bot
            assign sla_d[gi] = 1'b0;
            assign rol_d[gi] = d[WIDTH-1];
        end else begin : g_not_bot
            assign sla_d[gi] = d[gi-1];
            assign rol_d[gi] = d[gi-1];
        end
    end

    // Select the step for the active operation; PASS leaves data untouched
    always_comb begin
        next_d = d;
        case (mode)
            MODE_SRL:  next_d = srl_d;
            MODE_SLA:  next_d = sla_d;
            MODE_ROL:  next_d = rol_d;
            default:   next_d = d;
        endcase
    end

`ifdef SHIFT_OVF_EN
    // Arithmetic left shift overflows when the sign bit is about to change
    assign step_ovf = (mode == MODE_SLA) && (d[WIDTH-1] != d[WIDTH-2]);
`else
    assign step_ovf = 1'b0;
`endif

endmodule

// File: rtl/shifter_seq_rev.sv
// shifter_seq_rev: multi-cycle handshaked shifter doing SRL, SLA and ROL
// one bit per clock, with a PASS mode. The result is held in DONE until
// the consumer accepts it. Optional macro: SHIFT_OVF_EN builds the sticky
// SLA overflow flag; without it Ovf is constant 0.
// CNT_W must satisfy 2**CNT_W == WIDTH.
module shifter_seq_rev
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    shifter_seq_rev_if.slave  bus
);

    state_e           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] cnt_reg;
    mode_e            mode_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] step_d_next;
    logic             step_ovf;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d        (data_reg),
        .mode     (mode_reg),
        .next_d   (step_d_next),
        .step_ovf (step_ovf)
    );

    // Control FSM and datapath registers; every output comes from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            data_reg      <= '0;
            cnt_reg       <= '0;
            mode_reg      <= MODE_SRL;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.In_Valid) begin
                        data_reg     <= bus.Shift_In;
                        mode_reg     <= mode_e'(bus.Mode);
                        // PASS never steps, whatever amount is offered
                        cnt_reg      <= (mode_e'(bus.Mode) == MODE_PASS) ? '0 : bus.Shift_Val;
                        ovf_reg      <= 1'b0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg != '0) begin
                        data_reg <= step_d_next;
                        cnt_reg  <= cnt_reg - 1'b1;
                        if (step_ovf) begin
                            ovf_reg <= 1'b1;
                        end
                    end else begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.Out_Ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.In_Ready  = in_ready_reg;
    assign bus.Out_Valid = out_valid_reg;
    assign bus.Shift_Out = data_reg;
    assign bus.Ovf       = ovf_reg;

endmodule

// File: tb/tb_shifter_seq_rev.sv
// Self-checking bench for shifter_seq_rev: directed test-plan cases plus
// random operations checked against an arithmetic reference model.
module tb_shifter_seq_rev;

    localparam int W = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    shifter_seq_rev_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shifter_seq_rev #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-operation result from plain arithmetic
    function automatic logic [15:0] ref_out(input logic [1:0] m, input logic [15:0] x, input int n);
        logic [31:0] v;
        v = {16'h0, x};
        case (m)
            2'b00: ref_out = 16'(v >> n);
            2'b01: ref_out = 16'(v << n);
            2'b10: ref_out = (n == 0) ? x : 16'((v << n) | (v >> (16 - n)));
            default: ref_out = x;
        endcase
    endfunction

    // SLA overflows iff the top n+1 bits are not all equal
    function automatic logic ref_ovf(input logic [1:0] m, input logic [15:0] x, input int n);
        logic [31:0] top;
        logic [31:0] ones;
        ref_ovf = 1'b0;
`ifdef SHIFT_OVF_EN
        if (m == 2'b01) begin
            top  = {16'h0, x} >> (15 - n);
            ones = (32'd1 << (n + 1)) - 32'd1;
            ref_ovf = !(top == 32'd0 || top == ones);
        end
`endif
    endfunction

    // One operation: offer, count latency, check result, optional backpressure
    task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] x,
                          input int n, input int hold);
        int edges;
        int neff;
        logic [15:0] exp_d;
        logic        exp_o;
        neff  = (m == 2'b11) ? 0 : n;
        exp_d = ref_out(m, x, neff);
        exp_o = ref_ovf(m, x, neff);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.In_Ready), 32'd1);
        bus.In_Valid  = 1'b1;
        bus.Shift_In  = x;
        bus.Shift_Val = 4'(n);
        bus.Mode      = m;
        bus.Out_Ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus.In_Valid = 1'b0;
        edges = 0;
        while (!bus.Out_Valid && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(edges), 32'(neff + 1));
        chk({tag, ".out"}, 32'(bus.Shift_Out), 32'(exp_d));
        chk({tag, ".ovf"}, 32'(bus.Ovf), 32'(exp_o));
        for (int i = 0; i < hold; i++) begin
            bus.In_Valid = 1'b1;
            bus.Shift_In = 16'($urandom);
            bus.Mode     = 2'($urandom);
            @(posedge clk);
            @(negedge clk);
            bus.In_Valid = 1'b0;
            chk({tag, ".hold_valid"}, 32'(bus.Out_Valid), 32'd1);
            chk({tag, ".hold_out"}, 32'(bus.Shift_Out), 32'(exp_d));
            chk({tag, ".hold_ovf"}, 32'(bus.Ovf), 32'(exp_o));
            chk({tag, ".hold_inrdy"}, 32'(bus.In_Ready), 32'd0);
        end
        bus.Out_Ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".released"}, 32'(bus.Out_Valid), 32'd0);
        chk({tag, ".ready_again"}, 32'(bus.In_Ready), 32'd1);
        $display("op %s mode=%0d in=%04h n=%0d hold=%0d -> out=%04h ovf=%0d", tag, m, x, n,
                 hold, exp_d, exp_o);
    endtask

    initial begin
        int seen_valid;
        bus.In_Valid  = 1'b0;
        bus.Shift_In  = '0;
        bus.Shift_Val = '0;
        bus.Mode      = 2'b00;
        bus.Out_Ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", 32'(bus.In_Ready), 32'd1);
        chk("reset.out_valid", 32'(bus.Out_Valid), 32'd0);
        chk("reset.shift_out", 32'(bus.Shift_Out), 32'd0);
        chk("reset.ovf", 32'(bus.Ovf), 32'd0);
        rst = 1'b0;

        run_op("srl_8001_4", 2'b00, 16'h8001, 4, 0);
        run_op("rol_8001_4", 2'b10, 16'h8001, 4, 0);
        run_op("rol_f00f_15", 2'b10, 16'hF00F, 15, 0);
        run_op("sla_4000_1", 2'b01, 16'h4000, 1, 0);
        run_op("sla_ffff_3", 2'b01, 16'hFFFF, 3, 0);
        run_op("pass_1234_9", 2'b11, 16'h1234, 9, 0);
        run_op("srl_abcd_0", 2'b00, 16'hABCD, 0, 0);
        run_op("bp_sla_3", 2'b01, 16'h5A5A, 7, 3);

        // Reset in the middle of a long shift discards the operation
        @(negedge clk);
        bus.In_Valid  = 1'b1;
        bus.Shift_In  = 16'hFFFF;
        bus.Shift_Val = 4'd12;
        bus.Mode      = 2'b00;
        bus.Out_Ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.In_Valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.out_valid", 32'(bus.Out_Valid), 32'd0);
        chk("rst_mid.shift_out", 32'(bus.Shift_Out), 32'd0);
        chk("rst_mid.in_ready", 32'(bus.In_Ready), 32'd1);
        seen_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Out_Valid) seen_valid++;
        end
        chk("rst_mid.no_result", 32'(seen_valid), 32'd0);
        $display("op rst_mid srl ffff n=12 reset after 5 cycles -> discarded");

        for (int k = 0; k < 40; k++) begin
            run_op($sformatf("rand%0d", k), 2'($urandom), 16'($urandom),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
